// File: rtl/diff_seq_unit_if.sv
// Request/response bundle for diff_seq_unit: the execute stage drives start/A/B
// and stalls on busy; the unit reports done/diff/eq.
interface diff_seq_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [5:0]       diff;
   logic             eq;

   modport master (
      output start, A, B,
      input  busy, done, diff, eq
   );

   modport slave (
      input  start, A, B,
      output busy, done, diff, eq
   );
endinterface

// File: rtl/diff_seq_unit.sv
// Sequenced DIFF unit: finds the lowest bit where A and B differ by scanning A^B
// CHUNK bits per cycle. Define DIFF_ZERO_SKIP_EN to short-circuit equal operands.
module diff_seq_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input logic             clk,
   input logic             rst,
   diff_seq_unit_if.slave  bus
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int IW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;
   localparam int XW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [5:0]       diff_q, diff_d;
   logic             eq_q, eq_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [XW-1:0]    base;
   logic [CHUNK-1:0] chunk;
   logic [IW-1:0]    idx;

   // Position of the lowest set bit in a chunk; higher bits are overridden by lower ones.
   function automatic logic [IW-1:0] lowest_set(input logic [CHUNK-1:0] c);
      logic [IW-1:0] r;
      r = {IW{1'b0}};
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (c[i]) begin
            r = IW'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Chunk slice and encode; CHUNK is a power of two so the base is {cnt, zeros}.
   always_comb begin
      base  = XW'({cnt_q, {IW{1'b0}}});
      chunk = x_q[base +: CHUNK];
      idx   = lowest_set(chunk);
   end

   // Next-state and datapath update for the IDLE -> SCAN -> DONE sequence.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      eq_d    = eq_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               x_d     = bus.A ^ bus.B;
               cnt_d   = {CW{1'b0}};
               eq_d    = 1'b0;
               diff_d  = 6'd0;
               state_d = S_SCAN;
`ifdef DIFF_ZERO_SKIP_EN
               if (x_d == {WIDTH{1'b0}}) begin
                  eq_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SCAN;
               end
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            if (chunk != {CHUNK{1'b0}}) begin
               diff_d  = 6'({cnt_q, idx});
               state_d = S_DONE;
            end else if (cnt_q == LAST_CNT) begin
               eq_d    = 1'b1;
               diff_d  = 6'd0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Status flags are registered from the next state so they line up with it.
      busy_d = (state_d == S_SCAN) || (state_d == S_DONE);
      done_d = (state_d == S_DONE);
   end

   // State and result registers, cleared asynchronously at any point in a scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         diff_q  <= 6'd0;
         eq_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         eq_q    <= eq_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.eq   = eq_q;
endmodule
